// File: rtl/dmem_arbiter.sv
// Data-memory arbiter between the core MEM stage and the GEMM burst port.
//
// Grants the single memory port to one requester at a time, alternating
// fairly when both are waiting, and sequences multi-beat GEMM bursts.
//
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   core_mem_read/write, core_addr,
//   core_wdata, core_wmask          core load/store request (held while stalled)
//   core_rdata, core_stall          load data / pipeline freeze
//   gemm_req, gemm_we, gemm_addr,
//   gemm_len, gemm_wdata            burst request (len = beats - 1)
//   gemm_gnt, gemm_rvalid,
//   gemm_rdata, gemm_done           beat accept, read beat, burst end pulse
//   mem_req, mem_we, mem_addr,
//   mem_wdata, mem_wmask            memory request
//   mem_ready, mem_rdata            memory accept, read data one cycle later
module dmem_arbiter #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              core_mem_read,
    input  logic              core_mem_write,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    input  logic [3:0]        core_wmask,
    output logic [DATA_W-1:0] core_rdata,
    output logic              core_stall,
    input  logic              gemm_req,
    input  logic              gemm_we,
    input  logic [ADDR_W-1:0] gemm_addr,
    input  logic [3:0]        gemm_len,
    input  logic [DATA_W-1:0] gemm_wdata,
    output logic              gemm_gnt,
    output logic              gemm_rvalid,
    output logic [DATA_W-1:0] gemm_rdata,
    output logic              gemm_done,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [3:0]        mem_wmask,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [ADDR_W-1:0] BeatBytes = ADDR_W'(DATA_W / 8);

    typedef enum logic [2:0] {
        StIdle,
        StCore,
        StCoreResp,
        StGemm,
        StGemmDrain
    } state_e;

    state_e            state_q, state_d;
    logic              last_gemm_q, last_gemm_d;   // 1: GEMM owned the port last
    logic [ADDR_W-1:0] gaddr_q, gaddr_d;
    logic [3:0]        glen_q, glen_d;
    logic [3:0]        beat_q, beat_d;
    logic              gwe_q, gwe_d;
    logic              rvalid_q, rvalid_d;        // a GEMM read was accepted last cycle

    logic core_req;
    logic core_wr;
    logic core_done;
    logic last_beat;

    assign core_req  = core_mem_read | core_mem_write;
    // A request with both read and write set is a store.
    assign core_wr   = core_mem_write;
    assign last_beat = (beat_q == glen_q);

    always_comb begin
        state_d     = state_q;
        last_gemm_d = last_gemm_q;
        gaddr_d     = gaddr_q;
        glen_d      = glen_q;
        beat_d      = beat_q;
        gwe_d       = gwe_q;
        rvalid_d    = 1'b0;

        mem_req     = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        mem_wmask   = 4'h0;
        gemm_gnt    = 1'b0;
        gemm_done   = 1'b0;
        core_done   = 1'b0;
        core_rdata  = '0;

        unique case (state_q)
            StIdle: begin
                if (core_req && (last_gemm_q || !gemm_req)) begin
                    state_d = StCore;
                end else if (gemm_req) begin
                    gaddr_d = gemm_addr;
                    glen_d  = gemm_len;
                    gwe_d   = gemm_we;
                    beat_d  = '0;
                    state_d = StGemm;
                end
            end
            StCore: begin
                mem_req   = 1'b1;
                mem_we    = core_wr;
                mem_addr  = core_addr;
                mem_wdata = core_wdata;
                mem_wmask = core_wr ? core_wmask : 4'hF;
                if (mem_ready) begin
                    last_gemm_d = 1'b0;
                    if (core_wr) begin
                        core_done = 1'b1;
                        state_d   = StIdle;
                    end else begin
                        state_d = StCoreResp;
                    end
                end
            end
            StCoreResp: begin
                core_done  = 1'b1;
                core_rdata = mem_rdata;
                state_d    = StIdle;
            end
            StGemm: begin
                mem_req   = 1'b1;
                mem_we    = gwe_q;
                mem_addr  = gaddr_q;
                mem_wdata = gemm_wdata;
                mem_wmask = 4'hF;
                if (mem_ready) begin
                    gemm_gnt = 1'b1;
                    rvalid_d = !gwe_q;
                    gaddr_d  = gaddr_q + BeatBytes;
                    beat_d   = beat_q + 4'd1;
                    if (last_beat) begin
                        last_gemm_d = 1'b1;
                        beat_d      = '0;
                        if (gwe_q) begin
                            gemm_done = 1'b1;
                            state_d   = StIdle;
                        end else begin
                            // Last read beat still has its data in flight.
                            state_d = StGemmDrain;
                        end
                    end
                end
            end
            StGemmDrain: begin
                gemm_done = 1'b1;
                state_d   = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        core_stall = core_req & ~core_done;
    end

    assign gemm_rvalid = rvalid_q;
    assign gemm_rdata  = rvalid_q ? mem_rdata : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            last_gemm_q <= 1'b1;   // core wins the first tie
            gaddr_q     <= '0;
            glen_q      <= '0;
            beat_q      <= '0;
            gwe_q       <= 1'b0;
            rvalid_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_gemm_q <= last_gemm_d;
            gaddr_q     <= gaddr_d;
            glen_q      <= glen_d;
            beat_q      <= beat_d;
            gwe_q       <= gwe_d;
            rvalid_q    <= rvalid_d;
        end
    end

endmodule
